// File: rtl/move_issuer.sv
// Initiator side of the board-update handshake: turns cursor/button events into
// updater requests and owns the committed board, ko board, turn and pass tracking.
module move_issuer #(
  parameter int TIMEOUT    = 1024,
  parameter int MOVE_CNT_W = 9
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  input  logic [3:0]            row_in,
  input  logic [3:0]            col_in,
  input  logic                  place_pulse,
  input  logic                  pass_pulse,
  input  logic [8:0][8:0][1:0]  next_board,
  input  logic                  board_valid,
  input  logic                  board_invalid,
  output logic                  start_flag,
  output logic [7:0]            move_out,
  output logic                  turn,
  output logic [8:0][8:0][1:0]  board_bus,
  output logic [8:0][8:0][1:0]  ko_board,
  output logic                  reject_pulse,
  output logic                  timeout_err,
  output logic                  busy,
  output logic                  game_over,
  output logic [MOVE_CNT_W-1:0] move_count
);

  typedef enum logic [2:0] {
    IDLE, ISSUE, WAIT_RESP, COMMIT, REJECT, GAME_OVER
  } state_t;

  localparam int              CNT_W    = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [7:0]       PASS_MOVE = 8'hFF;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] wait_cnt;
  logic [1:0]       pass_streak;

  logic on_board, cell_free, issue_place, issue_pass, accept_resp, timed_out;

  always_comb begin
    on_board    = (row_in <= 4'd8) && (col_in <= 4'd8);
    cell_free   = on_board && (board_bus[row_in][col_in] == 2'b00);
    issue_place = (state == IDLE) && place_pulse && cell_free;
    issue_pass  = (state == IDLE) && !place_pulse && pass_pulse;
    accept_resp = (state == WAIT_RESP) && board_valid && !board_invalid;
    // A response in the same cycle as the last wait cycle beats the timeout.
    timed_out   = (state == WAIT_RESP) && !board_valid && !board_invalid &&
                  ((wait_cnt + 1'b1) == CNT_LAST);
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others, independent of block order.
  always_ff @(posedge clk_in) begin
    if (!rst_in) state <= IDLE;
    else         state <= state_nxt;
  end

  // NOTE: the default assignment first keeps this block purely combinational;
  // any path that skipped state_nxt would otherwise infer a latch.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (place_pulse)     state_nxt = cell_free ? ISSUE : REJECT;
        else if (pass_pulse) state_nxt = ISSUE;
      end
      ISSUE:     state_nxt = WAIT_RESP;
      WAIT_RESP: begin
        if (board_invalid)    state_nxt = REJECT;
        else if (board_valid) state_nxt = COMMIT;
        else if (timed_out)   state_nxt = REJECT;
      end
      COMMIT:    state_nxt = (pass_streak == 2'd2) ? GAME_OVER : IDLE;
      REJECT:    state_nxt = IDLE;
      GAME_OVER: state_nxt = GAME_OVER;
      default:   state_nxt = IDLE;
    endcase
  end

  always_comb begin
    start_flag   = (state == ISSUE);
    reject_pulse = (state == REJECT);
    game_over    = (state == GAME_OVER);
    busy         = (state != IDLE) && (state != GAME_OVER);
  end

  // The committed result is captured on the accepting edge so board_bus and
  // turn update one cycle after board_valid; COMMIT then only routes the FSM.
  // NOTE: the board arrays are reset explicitly because a cleared board is the
  // architectural starting position, not scratch storage.
  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      move_out    <= PASS_MOVE;
      turn        <= 1'b0;
      board_bus   <= '0;
      ko_board    <= '0;
      timeout_err <= 1'b0;
      move_count  <= '0;
      pass_streak <= 2'd0;
      wait_cnt    <= '0;
    end else begin
      if (issue_place)     move_out <= {row_in, col_in};
      else if (issue_pass) move_out <= PASS_MOVE;

      if (state == ISSUE) wait_cnt <= '0;
      else if ((state == WAIT_RESP) && !board_valid && !board_invalid)
        wait_cnt <= wait_cnt + 1'b1;

      if (timed_out) timeout_err <= 1'b1;

      if (accept_resp) begin
        ko_board    <= board_bus;
        board_bus   <= next_board;
        turn        <= ~turn;
        move_count  <= move_count + 1'b1;
        pass_streak <= (move_out == PASS_MOVE) ? pass_streak + 2'd1 : 2'd0;
      end
    end
  end

endmodule

// File: tb/tb_move_issuer.sv
// Directed bench for move_issuer: place/commit, rejects, updater reject,
// double pass to game over, timeout and mid-request reset.
module tb_move_issuer;

  logic                 clk_in = 1'b0;
  logic                 rst_in;
  logic [3:0]           row_in, col_in;
  logic                 place_pulse, pass_pulse;
  logic [8:0][8:0][1:0] next_board;
  logic                 board_valid, board_invalid;
  logic                 start_flag;
  logic [7:0]           move_out;
  logic                 turn;
  logic [8:0][8:0][1:0] board_bus, ko_board;
  logic                 reject_pulse, timeout_err, busy, game_over;
  logic [8:0]           move_count;

  int n_checks = 0;
  int n_pass   = 0;

  logic [8:0][8:0][1:0] empty_b, b44;

  move_issuer #(.TIMEOUT(16), .MOVE_CNT_W(9)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .row_in(row_in), .col_in(col_in),
    .place_pulse(place_pulse), .pass_pulse(pass_pulse), .next_board(next_board),
    .board_valid(board_valid), .board_invalid(board_invalid),
    .start_flag(start_flag), .move_out(move_out), .turn(turn),
    .board_bus(board_bus), .ko_board(ko_board), .reject_pulse(reject_pulse),
    .timeout_err(timeout_err), .busy(busy), .game_over(game_over),
    .move_count(move_count)
  );

  always #5 clk_in = ~clk_in;

  task automatic check(input string tag, input logic [161:0] act, input logic [161:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, act, exp);
  endtask

  // Inputs change and outputs are sampled 1 time unit after the rising edge.
  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, ".busy"},     busy,         1'b0);
    check({tag, ".start"},    start_flag,   1'b0);
    check({tag, ".move"},     move_out,     8'hFF);
    check({tag, ".turn"},     turn,         1'b0);
    check({tag, ".board"},    board_bus,    empty_b);
    check({tag, ".ko"},       ko_board,     empty_b);
    check({tag, ".count"},    move_count,   9'd0);
    check({tag, ".tout"},     timeout_err,  1'b0);
    check({tag, ".over"},     game_over,    1'b0);
    check({tag, ".reject"},   reject_pulse, 1'b0);
  endtask

  initial begin
    empty_b = '0;
    b44 = '0;
    b44[4][4] = 2'b01;
    rst_in = 1'b0; row_in = '0; col_in = '0; place_pulse = 0; pass_pulse = 0;
    next_board = '0; board_valid = 0; board_invalid = 0;
    step(); step();
    rst_in = 1'b1;
    check_reset_values("reset");

    // Place at (4,4) and accept
    row_in = 4'd4; col_in = 4'd4; place_pulse = 1;
    step(); place_pulse = 0;
    check("p44.start", start_flag, 1'b1);
    check("p44.move",  move_out,   8'h44);
    check("p44.busy",  busy,       1'b1);
    step();
    check("p44.start_once", start_flag, 1'b0);
    next_board = b44; board_valid = 1;
    step(); board_valid = 0;
    check("p44.board", board_bus,  b44);
    check("p44.ko",    ko_board,   empty_b);
    check("p44.turn",  turn,       1'b1);
    check("p44.count", move_count, 9'd1);
    step();
    check("p44.idle",  busy,       1'b0);

    // Occupied cell
    place_pulse = 1;
    step(); place_pulse = 0;
    check("occ.reject", reject_pulse, 1'b1);
    check("occ.start",  start_flag,   1'b0);
    check("occ.turn",   turn,         1'b1);
    step();
    check("occ.reject_one", reject_pulse, 1'b0);
    check("occ.start2",     start_flag,   1'b0);

    // Off-board row 9
    row_in = 4'd9; col_in = 4'd0; place_pulse = 1;
    step(); place_pulse = 0;
    check("off.reject", reject_pulse, 1'b1);
    check("off.start",  start_flag,   1'b0);
    step();
    check("off.start2", start_flag,   1'b0);

    // Updater rejects; both response lines high, invalid must win
    row_in = 4'd2; col_in = 4'd3; place_pulse = 1;
    step(); place_pulse = 0;
    check("ko.start", start_flag, 1'b1);
    for (int i = 1; i <= 5; i++) begin
      step();
      check($sformatf("ko.hold%0d", i), move_out, 8'h23);
    end
    next_board = empty_b; board_invalid = 1; board_valid = 1;
    step(); board_invalid = 0; board_valid = 0;
    check("ko.reject", reject_pulse, 1'b1);
    check("ko.board",  board_bus,    b44);
    check("ko.ko",     ko_board,     empty_b);
    check("ko.turn",   turn,         1'b1);
    check("ko.count",  move_count,   9'd1);
    step();

    // Two passes -> game over
    next_board = b44;
    for (int p = 0; p < 2; p++) begin
      pass_pulse = 1;
      step(); pass_pulse = 0;
      check($sformatf("pass%0d.start", p), start_flag, 1'b1);
      check($sformatf("pass%0d.move", p),  move_out,   8'hFF);
      step();
      board_valid = 1;
      step(); board_valid = 0;
      check($sformatf("pass%0d.count", p), move_count, 9'(2 + p));
      check($sformatf("pass%0d.turn", p),  turn,       (p == 0) ? 1'b0 : 1'b1);
      check($sformatf("pass%0d.ko", p),    ko_board,   b44);
      step();
      check($sformatf("pass%0d.over", p),  game_over,  (p == 0) ? 1'b0 : 1'b1);
    end
    check("over.busy", busy, 1'b0);
    row_in = 4'd0; col_in = 4'd0; place_pulse = 1;
    step(); place_pulse = 0;
    check("over.start",  start_flag,   1'b0);
    check("over.reject", reject_pulse, 1'b0);
    step();
    check("over.stay",   game_over,    1'b1);
    check("over.start2", start_flag,   1'b0);

    // Reset out of game over; place wins over simultaneous pass; then time out
    rst_in = 0; step(); rst_in = 1;
    check("rst2.over", game_over, 1'b0);
    row_in = 4'd0; col_in = 4'd0; place_pulse = 1; pass_pulse = 1;
    step(); place_pulse = 0; pass_pulse = 0;
    check("prio.move",  move_out,   8'h00);
    check("prio.start", start_flag, 1'b1);
    for (int i = 1; i <= 15; i++) step();
    check("to.early_reject", reject_pulse, 1'b0);
    check("to.early_err",    timeout_err,  1'b0);
    step();
    check("to.reject", reject_pulse, 1'b1);
    check("to.err",    timeout_err,  1'b1);
    step();
    check("to.sticky", timeout_err,  1'b1);
    check("to.idle",   busy,         1'b0);

    // Reset in the middle of WAIT_RESP
    row_in = 4'd1; col_in = 4'd1; place_pulse = 1;
    step(); place_pulse = 0;
    step(); step();
    check("mid.busy", busy, 1'b1);
    rst_in = 0;
    step();
    check_reset_values("midrst");
    rst_in = 1;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/move_issuer.md
Name: move_issuer

Overview:
- Initiator side of the board-update handshake: turns player cursor/button events into move requests for the board updater and commits or rejects the result.
- Owns the authoritative committed board, ko reference board, side-to-move and pass/game-over tracking.
- Sits between the input/cursor logic and the board updater.
- Its outputs drive the updater's start/move/turn/board/ko inputs.
- Its inputs take the updater's next_board, board_valid and board_invalid.

Parameters:
- TIMEOUT, 1024: cycles to wait for an updater response before abandoning a request.
- MOVE_CNT_W, 9: width of the committed-move counter.

Ports:
- clk_in  input  1  system clock
- rst_in  input  1  synchronous, active-low reset
- row_in  input  4  cursor row, valid 0-8
- col_in  input  4  cursor column, valid 0-8
- place_pulse  input  1  one-cycle request to place a stone at the cursor
- pass_pulse  input  1  one-cycle request to pass
- next_board  input  2x[8:0][8:0]  candidate board from the updater
- board_valid  input  1  updater accepts the candidate
- board_invalid  input  1  updater rejects the candidate
- start_flag  output  1  one-cycle request strobe to the updater
- move_out  output  8  {row,col}; 8'hFF means pass
- turn  output  1  0 = Black to move, 1 = White to move
- board_bus  output  2x[8:0][8:0]  committed board
- ko_board  output  2x[8:0][8:0]  position before the last committed move
- reject_pulse  output  1  one cycle per rejected request
- timeout_err  output  1  sticky; set by a response timeout
- busy  output  1  high in any state except IDLE and GAME_OVER
- game_over  output  1  sticky after two consecutive passes
- move_count  output  MOVE_CNT_W  committed moves, passes included

Behaviour:
- Cell encoding: 00 empty, 01 Black, 10 White.
- Reset (rst_in==0 at a clock edge), from any state including mid-request:
  - state IDLE; board_bus and ko_board all 00; turn 0; start_flag 0; move_out 8'hFF.
  - reject_pulse 0, timeout_err 0, game_over 0, move_count 0, pass_streak 0, timeout counter 0.
- States: IDLE, ISSUE, WAIT_RESP, COMMIT, REJECT, GAME_OVER.
- IDLE:
  - place_pulse has priority over pass_pulse when both arrive in the same cycle.
  - place_pulse with row_in>8 or col_in>8 -> REJECT; the updater is not contacted.
  - place_pulse with board_bus[row][col]!=00 -> REJECT; the updater is not contacted.
  - Any other place_pulse -> latch move_out={row_in,col_in}, go to ISSUE.
  - pass_pulse -> move_out=8'hFF, go to ISSUE.
  - Pulses arriving in any other state are dropped.
- ISSUE:
  - start_flag=1 for exactly this one cycle; clear the timeout counter; go to WAIT_RESP.
- WAIT_RESP:
  - move_out, turn, board_bus and ko_board are held stable from ISSUE until the state is left.
  - board_invalid -> REJECT. This also applies when board_valid and board_invalid are high together (invalid wins).
  - board_valid alone -> COMMIT.
  - Otherwise increment the counter; if it reaches TIMEOUT-1, set timeout_err and go to REJECT.
  - A valid or invalid response arriving in the same cycle as the timeout takes precedence over the timeout.
- COMMIT (one cycle), all updates simultaneous:
  - ko_board<=board_bus (old value).
  - board_bus<=next_board.
  - turn<=~turn.
  - move_count wraps at 2^MOVE_CNT_W.
  - pass_streak<=(move_out==8'hFF) ? pass_streak+1 : 0.
  - If the new pass_streak is 2, go to GAME_OVER; else go to IDLE.
- REJECT (one cycle):
  - reject_pulse=1; board, ko_board, turn and move_count unchanged; go to IDLE.
  - A rejected pass does not change pass_streak.
- GAME_OVER:
  - game_over=1; all inputs ignored; left only by reset.
- Latency:
  - IDLE place/pass to start_flag: 1 cycle.
  - board_valid to board_bus/turn update: 1 cycle.
  - board_valid to back in IDLE: 2 cycles.
- board_valid/board_invalid seen outside WAIT_RESP are ignored.

Test Plan:
- Reset, then place_pulse at (4,4):
  - start_flag high 1 cycle later with move_out=8'h44.
  - Bench drives next_board with [4][4]=01 and board_valid.
  - Next cycle: board_bus[4][4]=01, ko_board all 00, turn=1, move_count=1.
- Occupied cell: with [4][4]=01 committed, place at (4,4):
  - reject_pulse for 1 cycle; start_flag never asserted; turn unchanged.
- Off-board cell: place at row 9 -> reject_pulse; start_flag never asserted.
- Updater rejects (simulated ko):
  - place at (2,3); bench returns board_invalid 5 cycles after start_flag.
  - Expect reject_pulse; board_bus, ko_board and turn unchanged; move_out held at 8'h23 for all 5 wait cycles.
- Two passes:
  - pass_pulse then pass_pulse, each accepted with board_valid.
  - Expect move_out=8'hFF both times, turn back to its start value, move_count +2, game_over=1.
  - A later place_pulse is ignored.
- Timeout, then reset:
  - With TIMEOUT=16 and no response: timeout_err=1 and reject_pulse 16 cycles after start_flag.
  - Assert rst_in=0 while in WAIT_RESP of the next request: next cycle state IDLE, all outputs at reset values.
